mem_ctrl: RTL and testbench

Byte-wide memory controller that arbitrates the instruction-fetch (IF) and load/store (MEM) ports of the 5-stage pipeline onto a single 8-bit synchronous RAM. It assembles or splits 1/2/4-byte little-endian transfers over several cycles. It also generates the `stall_if` and `stall_mem` requests consumed by the pipeline stall controller, which converts them into the per-stage stall vector.

---
 rtl/mem_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_mem_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-wide RAM controller shared by the IF and MEM pipeline ports.
// Splits/assembles 1/2/4-byte little-endian transfers over several cycles,
// MEM has priority over IF when both request in IDLE.
// Optional feature macro: MEM_CTRL_IF_ABORT_EN adds the if_abort input that
// cancels an in-flight instruction fetch.
module mem_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [31:0]       if_inst,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_len,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    input  logic [7:0]        ram_din,
    output logic [7:0]        ram_dout,
    output logic [ADDR_W-1:0] ram_a,
    output logic              ram_wr,
`ifdef MEM_CTRL_IF_ABORT_EN
    input  logic              if_abort,
`endif
    output logic              stall_if,
    output logic              stall_mem
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_reg, state_next;
    logic [2:0]          cnt_reg, cnt_next;
    logic                port_mem_reg, port_mem_next;   // 1 = MEM owns the transfer
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [2:0]          len_reg, len_next;             // byte count 1/2/4
    logic                we_reg, we_next;
    logic [31:0]         wdata_reg, wdata_next;
    logic [31:0]         rbuf_reg, rbuf_next;           // read assembly buffer
    logic [31:0]         if_inst_reg, if_inst_next;
    logic [31:0]         mem_rdata_reg, mem_rdata_next;

    logic                abort_if;
    logic [ADDR_W-1:0]   cnt_ext;
    logic [3:0]          lane_cap;
    logic [31:0]         rbuf_cap;

`ifdef MEM_CTRL_IF_ABORT_EN
    assign abort_if = if_abort;
`else
    assign abort_if = 1'b0;
`endif

    assign cnt_ext = ADDR_W'(cnt_reg);

    // Byte lane gi receives ram_din when cnt points one past its address
    // (the RAM returns data one cycle after the address).
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign lane_cap[gi] = (cnt_reg == 3'(gi + 1));
            assign rbuf_cap[8*gi +: 8] = lane_cap[gi] ? ram_din : rbuf_reg[8*gi +: 8];
        end
    endgenerate

    assign if_inst   = if_inst_reg;
    assign mem_rdata = mem_rdata_reg;
    assign stall_if  = if_req & ~if_done;
    assign stall_mem = mem_req & ~mem_done;

    // Next-state, datapath next values and RAM/done outputs.
    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        port_mem_next  = port_mem_reg;
        addr_next      = addr_reg;
        len_next       = len_reg;
        we_next        = we_reg;
        wdata_next     = wdata_reg;
        rbuf_next      = rbuf_reg;
        if_inst_next   = if_inst_reg;
        mem_rdata_next = mem_rdata_reg;
        ram_wr         = 1'b0;
        ram_a          = '0;
        ram_dout       = '0;
        if_done        = 1'b0;
        mem_done       = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (mem_req) begin
                    port_mem_next = 1'b1;
                    addr_next     = ADDR_W'(mem_addr);
                    len_next      = (mem_len == 2'b00) ? 3'd1 :
                                    (mem_len == 2'b01) ? 3'd2 : 3'd4;
                    we_next       = mem_we;
                    wdata_next    = mem_wdata;
                    rbuf_next     = '0;
                    cnt_next      = 3'd0;
                    state_next    = BUSY;
                end else if (if_req && !abort_if) begin
                    port_mem_next = 1'b0;
                    addr_next     = ADDR_W'(if_addr);
                    len_next      = 3'd4;
                    we_next       = 1'b0;
                    wdata_next    = '0;
                    rbuf_next     = '0;
                    cnt_next      = 3'd0;
                    state_next    = BUSY;
                end
            end
            BUSY: begin
                if (we_reg) begin
                    ram_wr   = 1'b1;
                    ram_a    = addr_reg + cnt_ext;
                    ram_dout = wdata_reg[{cnt_reg[1:0], 3'b000} +: 8];
                    if (cnt_reg == len_reg - 3'd1) begin
                        cnt_next   = 3'd0;
                        state_next = DONE;
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end else begin
                    if (cnt_reg < len_reg) begin
                        ram_a = addr_reg + cnt_ext;
                    end
                    rbuf_next = rbuf_cap;
                    if (cnt_reg == len_reg) begin
                        cnt_next   = 3'd0;
                        state_next = DONE;
                        if (port_mem_reg) begin
                            mem_rdata_next = rbuf_cap;
                        end else begin
                            if_inst_next = rbuf_cap;
                        end
                    end else begin
                        cnt_next = cnt_reg + 3'd1;
                    end
                end
                // A cancelled fetch leaves if_inst untouched and never reports done.
                if (!port_mem_reg && abort_if) begin
                    cnt_next     = 3'd0;
                    state_next   = IDLE;
                    if_inst_next = if_inst_reg;
                end
            end
            DONE: begin
                if (port_mem_reg) begin
                    mem_done = 1'b1;
                end else begin
                    if_done = 1'b1;
                end
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                cnt_next   = 3'd0;
            end
        endcase
    end

    // State register and byte counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 3'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Latched request copies and read result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_mem_reg  <= 1'b0;
            addr_reg      <= '0;
            len_reg       <= 3'd0;
            we_reg        <= 1'b0;
            wdata_reg     <= '0;
            rbuf_reg      <= '0;
            if_inst_reg   <= '0;
            mem_rdata_reg <= '0;
        end else begin
            port_mem_reg  <= port_mem_next;
            addr_reg      <= addr_next;
            len_reg       <= len_next;
            we_reg        <= we_next;
            wdata_reg     <= wdata_next;
            rbuf_reg      <= rbuf_next;
            if_inst_reg   <= if_inst_next;
            mem_rdata_reg <= mem_rdata_next;
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: directed vector table plus hand-written multi-cycle sequences
// for mem_ctrl, with a byte-wide synchronous RAM model (64 KiB, low 16 address bits).
module tb_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_done;
    logic [31:0] if_inst;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_len;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic [7:0]  ram_din;
    logic [7:0]  ram_dout;
    logic [31:0] ram_a;
    logic        ram_wr;
    logic        stall_if;
    logic        stall_mem;
`ifdef MEM_CTRL_IF_ABORT_EN
    logic        if_abort;
`endif

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] ram_mem [0:65535];

    typedef struct {
        bit          is_if;
        bit          we;
        logic [1:0]  len;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs [11];

    mem_ctrl #(.ADDR_W(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_inst   (if_inst),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_len   (mem_len),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout),
        .ram_a     (ram_a),
        .ram_wr    (ram_wr),
`ifdef MEM_CTRL_IF_ABORT_EN
        .if_abort  (if_abort),
`endif
        .stall_if  (stall_if),
        .stall_mem (stall_mem)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: write on strobe, read data one cycle after address.
    always @(posedge clk) begin
        if (ram_wr) ram_mem[ram_a[15:0]] <= ram_dout;
        ram_din <= ram_mem[ram_a[15:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic start_cycle();
        @(posedge clk);
        #1;
    endtask

    // One table transaction: request in cycle 0, wait for done, check latency/data.
    task automatic run_vec(input vec_t v, input int idx);
        int  c;
        bit  seen;
        logic d;
        start_cycle();
        if (v.is_if) begin
            if_req  = 1'b1;
            if_addr = v.addr;
        end else begin
            mem_req   = 1'b1;
            mem_we    = v.we;
            mem_len   = v.len;
            mem_addr  = v.addr;
            mem_wdata = v.wdata;
        end
        c    = 0;
        seen = 1'b0;
        while (!seen && c < 16) begin
            @(negedge clk);
            d = v.is_if ? if_done : mem_done;
            if (d) seen = 1'b1;
            else begin
                start_cycle();
                c++;
            end
        end
        chk($sformatf("vec%0d latency", idx), seen ? 32'(c) : 32'hFFFF_FFFF, 32'(v.exp_lat));
        if (!v.we)
            chk($sformatf("vec%0d rdata", idx), v.is_if ? if_inst : mem_rdata, v.exp_data);
        start_cycle();
        if_req  = 1'b0;
        mem_req = 1'b0;
        @(negedge clk);
        chk($sformatf("vec%0d done pulse width", idx), {30'd0, if_done, mem_done}, 32'd0);
        $display("vec%0d: if=%0d we=%0d len=%0d addr=0x%08h latency=%0d", idx, v.is_if, v.we, v.len, v.addr, c);
    endtask

    initial begin
        rst_n = 1'b0;  if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_len = 2'b00; mem_addr = '0; mem_wdata = '0;
`ifdef MEM_CTRL_IF_ABORT_EN
        if_abort = 1'b0;
`endif
        for (int i = 0; i < 65536; i++) ram_mem[i] = 8'h00;
        ram_mem[16'hFFFE] = 8'h13; ram_mem[16'hFFFF] = 8'h05;
        ram_mem[16'h3000] = 8'h34; ram_mem[16'h3001] = 8'h12;
        ram_mem[16'h0100] = 8'h78; ram_mem[16'h0101] = 8'h56;
        ram_mem[16'h0102] = 8'h34; ram_mem[16'h0103] = 8'h12;

        vecs[0]  = '{1'b0, 1'b1, 2'b10, 32'h0000_6000, 32'h1122_3344, 32'h0,          5};
        vecs[1]  = '{1'b0, 1'b0, 2'b10, 32'h0000_6000, 32'h0,         32'h1122_3344, 6};
        vecs[2]  = '{1'b0, 1'b0, 2'b01, 32'h0000_6002, 32'h0,         32'h0000_1122, 4};
        vecs[3]  = '{1'b0, 1'b0, 2'b00, 32'h0000_6001, 32'h0,         32'h0000_0033, 3};
        vecs[4]  = '{1'b0, 1'b1, 2'b01, 32'h0000_6004, 32'hFFFF_A5B6, 32'h0,          3};
        vecs[5]  = '{1'b0, 1'b0, 2'b11, 32'h0000_6004, 32'h0,         32'h0000_A5B6, 6};
        vecs[6]  = '{1'b1, 1'b0, 2'b10, 32'h0000_6000, 32'h0,         32'h1122_3344, 6};
        vecs[7]  = '{1'b0, 1'b0, 2'b00, 32'h0000_2003, 32'h0,         32'h0000_00AB, 3};
        vecs[8]  = '{1'b0, 1'b1, 2'b10, 32'hFFFF_FFFF, 32'hCAFE_F00D, 32'h0,          5};
        vecs[9]  = '{1'b1, 1'b0, 2'b00, 32'hFFFF_FFFF, 32'h0,         32'hCAFE_F00D, 6};
        vecs[10] = '{1'b0, 1'b0, 2'b00, 32'h0000_6003, 32'h0,         32'h0000_0011, 3};

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset if_done", if_done, 0);
        chk("reset mem_done", mem_done, 0);
        chk("reset if_inst", if_inst, 0);
        chk("reset mem_rdata", mem_rdata, 0);
        chk("reset ram_a", ram_a, 0);
        chk("reset ram_wr/dout", {ram_wr, ram_dout}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post-reset done", {if_done, mem_done}, 0);
        $display("reset: outputs checked");

        // IF word read wrapping through the top of the address space.
        start_cycle();
        if_req = 1'b1; if_addr = 32'hFFFF_FFFE;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) begin
                start_cycle();
                if (c == 7) if_req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("A c%0d ram_a", c), ram_a,
                (c == 1) ? 32'hFFFF_FFFE : (c == 2) ? 32'hFFFF_FFFF :
                (c == 3) ? 32'h0 : (c == 4) ? 32'h1 : 32'h0);
            chk($sformatf("A c%0d if_done", c), if_done, c == 6);
            chk($sformatf("A c%0d stall_if", c), stall_if, c <= 5);
            chk($sformatf("A c%0d ram_wr", c), ram_wr, 0);
        end
        chk("A if_inst", if_inst, 32'h0000_0513);
        $display("seqA: IF read 0xFFFFFFFE -> if_inst=0x%08h", if_inst);

        // MEM byte write.
        start_cycle();
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b00; mem_addr = 32'h2003; mem_wdata = 32'h0000_00AB;
        for (int c = 0; c <= 3; c++) begin
            if (c > 0) begin
                start_cycle();
                if (c == 3) mem_req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("B c%0d ram_wr", c), ram_wr, c == 1);
            chk($sformatf("B c%0d mem_done", c), mem_done, c == 2);
            chk($sformatf("B c%0d stall_mem", c), stall_mem, c <= 1);
            if (c == 1) begin
                chk("B ram_a", ram_a, 32'h2003);
                chk("B ram_dout", ram_dout, 32'hAB);
            end
        end
        $display("seqB: byte write 0x2003 <- 0xAB");

        // Simultaneous MEM half read and IF read: MEM first.
        start_cycle();
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b01; mem_addr = 32'h3000;
        if_req  = 1'b1; if_addr = 32'h0100;
        for (int c = 0; c <= 12; c++) begin
            if (c > 0) begin
                start_cycle();
                if (c == 5)  mem_req = 1'b0;
                if (c == 12) if_req  = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("C c%0d mem_done", c), mem_done, c == 4);
            chk($sformatf("C c%0d if_done", c), if_done, c == 11);
            chk($sformatf("C c%0d stall_if", c), stall_if, c <= 10);
            chk($sformatf("C c%0d stall_mem", c), stall_mem, c <= 3);
            if (c == 1) chk("C ram_a mem first", ram_a, 32'h3000);
            if (c == 6) chk("C ram_a if second", ram_a, 32'h0100);
            if (c == 4) chk("C mem_rdata", mem_rdata, 32'h0000_1234);
            if (c == 11) chk("C if_inst", if_inst, 32'h1234_5678);
        end
        $display("seqC: arbitration mem_rdata=0x%08h if_inst=0x%08h", mem_rdata, if_inst);

        // Reset in the middle of a word write.
        start_cycle();
        mem_req = 1'b1; mem_we = 1'b1; mem_len = 2'b10; mem_addr = 32'h4000; mem_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        start_cycle();
        @(negedge clk);
        chk("D c1 ram_dout", ram_dout, 32'hEF);
        start_cycle();
        @(negedge clk);
        chk("D c2 ram_wr", ram_wr, 1);
        chk("D c2 ram_a", ram_a, 32'h4001);
        #2;
        rst_n = 1'b0;
        mem_req = 1'b0;
        #1;
        chk("D async ram_wr", ram_wr, 0);
        chk("D async ram_a", ram_a, 0);
        chk("D async ram_dout", ram_dout, 0);
        chk("D async if_inst", if_inst, 0);
        chk("D async mem_rdata", mem_rdata, 0);
        chk("D async stall", {stall_if, stall_mem}, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk($sformatf("D idle%0d done/wr", c), {mem_done, if_done, ram_wr}, 0);
        end
        start_cycle();
        mem_req = 1'b1; mem_we = 1'b0; mem_len = 2'b10; mem_addr = 32'h4000;
        for (int c = 0; c <= 7; c++) begin
            if (c > 0) begin
                start_cycle();
                if (c == 7) mem_req = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("D rd c%0d mem_done", c), mem_done, c == 6);
            if (c == 1) chk("D rd ram_a from cnt 0", ram_a, 32'h4000);
            if (c == 6) chk("D rd partial write", mem_rdata, 32'h0000_00EF);
        end
        $display("seqD: reset mid-write, readback=0x%08h", mem_rdata);

        // Table of directed transfers.
        for (int i = 0; i < 11; i++) run_vec(vecs[i], i);
        chk("hold if_inst", if_inst, 32'hCAFE_F00D);
        chk("hold mem_rdata", mem_rdata, 32'h0000_0011);

`ifdef MEM_CTRL_IF_ABORT_EN
        // Abort an IF read in cycle 3; re-issued request granted in cycle 4.
        start_cycle();
        if_req = 1'b1; if_addr = 32'h6000;
        for (int c = 0; c <= 11; c++) begin
            if (c > 0) begin
                start_cycle();
                if (c == 3)  if_abort = 1'b1;
                if (c == 4)  if_abort = 1'b0;
                if (c == 11) if_req   = 1'b0;
            end
            @(negedge clk);
            chk($sformatf("E c%0d if_done", c), if_done, c == 10);
            if (c == 4) chk("E ram_a idle after abort", ram_a, 32'h0);
            if (c == 5) chk("E ram_a regrant", ram_a, 32'h6000);
            if (c == 10) chk("E if_inst", if_inst, 32'h1122_3344);
        end
        $display("seqE: IF abort and re-issue");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
